// File: rtl/sap1_controller_if.sv
// ----------------------------------------------------------------------------
// sap1_controller_if
//   Bundle between the SAP-1 controller-sequencer and the datapath it steers.
//
//   Signals
//     OPCODE  IR[7:4], driven by the datapath; must be stable from T4 to T6
//     STEP    advance enable (only when CTRL_SINGLE_STEP_EN is defined)
//     T       one-hot timing state, T[0]=T1 .. T[5]=T6
//     CON     control word {Cp,Ep,LM_N,CE_N,LI_N,EI_N,LA_N,Ea,Su,Eu,LB_N,LO_N}
//     HALT    high once HLT has been decoded, until CLR
//
//   Modports
//     master  the controller: consumes OPCODE/STEP, produces T/CON/HALT
//     slave   the datapath side: the mirror image
//
//   Handshake: there is no valid/ready pair on this bundle. CON is a level
//   that is valid between falling edges of CLK_N. In single-step builds,
//   STEP qualifies each falling edge: the ring moves only when STEP=1.
//
//   Configuration macro: CTRL_SINGLE_STEP_EN adds the STEP signal.
// ----------------------------------------------------------------------------
interface sap1_controller_if #(
  parameter int OPCODE_W = 4
);
  logic [OPCODE_W-1:0] OPCODE;
`ifdef CTRL_SINGLE_STEP_EN
  logic                STEP;
`endif
  logic [5:0]          T;
  logic [11:0]         CON;
  logic                HALT;

`ifdef CTRL_SINGLE_STEP_EN
  modport master (input OPCODE, input STEP, output T, output CON, output HALT);
  modport slave  (output OPCODE, output STEP, input T, input CON, input HALT);
`else
  modport master (input OPCODE, output T, output CON, output HALT);
  modport slave  (output OPCODE, input T, input CON, input HALT);
`endif
endinterface

// File: rtl/sap1_controller.sv
// ----------------------------------------------------------------------------
// sap1_controller
//   SAP-1 controller-sequencer: a six-state one-hot ring counter (T1..T6)
//   and a combinational control-word decoder. All state changes happen on
//   the falling edge of CLK_N so that the control word settles before the
//   next falling edge, where the datapath registers load from it.
//
//   Ports
//     CLK_N  system clock, state updates on the falling edge
//     CLR    synchronous active-high reset, sampled on the falling edge
//     bus    sap1_controller_if.master: OPCODE/STEP in, T/CON/HALT out.
//            T is the ring state itself and doubles as the state debug view;
//            HALT exposes the halt flag.
//
//   Configuration macro: CTRL_SINGLE_STEP_EN
//     defined   - the ring (and the halt flag) advance only on edges with
//                 STEP=1; CLR works regardless of STEP
//     undefined - the ring advances on every falling edge
// ----------------------------------------------------------------------------
module sap1_controller #(
  parameter int OPCODE_W = 4,
  parameter int T_STATES = 6
) (
  input  logic              CLK_N,
  input  logic              CLR,
  sap1_controller_if.master bus
);

  typedef enum logic [T_STATES-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  // Control words, bit order {Cp,Ep,LM_N,CE_N,LI_N,EI_N,LA_N,Ea,Su,Eu,LB_N,LO_N}
  localparam logic [11:0] CON_IDLE    = 12'h3E3;
  localparam logic [11:0] CON_FETCH1  = 12'h5E3;  // Ep, LM_N
  localparam logic [11:0] CON_FETCH2  = 12'hBE3;  // Cp
  localparam logic [11:0] CON_FETCH3  = 12'h263;  // CE_N, LI_N
  localparam logic [11:0] CON_EI_LM   = 12'h1A3;  // IR address -> MAR
  localparam logic [11:0] CON_CE_LA   = 12'h2C3;  // RAM -> A
  localparam logic [11:0] CON_CE_LB   = 12'h2E1;  // RAM -> B
  localparam logic [11:0] CON_ADD_LA  = 12'h3C7;  // ALU sum -> A
  localparam logic [11:0] CON_SUB_LA  = 12'h3CF;  // ALU difference -> A
  localparam logic [11:0] CON_EA_LO   = 12'h3F2;  // A -> OUT

  ring_e       state_q, state_d;
  logic        halt_q, halt_d;
  ring_e       ring_next;
  logic [11:0] con;
  logic        halt_out;
  logic        hlt_t4;
  logic        advance;

`ifdef CTRL_SINGLE_STEP_EN
  assign advance = bus.STEP;
`else
  assign advance = 1'b1;
`endif

  always_ff @(negedge CLK_N) begin
    if (CLR) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    ring_next = T1;
    con       = CON_IDLE;
    hlt_t4    = 1'b0;
    state_d   = state_q;
    halt_d    = halt_q;
    halt_out  = 1'b0;

    case (state_q)
      T1: begin ring_next = T2; con = CON_FETCH1; end
      T2: begin ring_next = T3; con = CON_FETCH2; end
      T3: begin ring_next = T4; con = CON_FETCH3; end
      T4: begin
        ring_next = T5;
        case (bus.OPCODE)
          OP_LDA, OP_ADD, OP_SUB: con = CON_EI_LM;
          OP_OUT:                 con = CON_EA_LO;
          OP_HLT: begin
            // HLT parks the ring at T4 and raises HALT in the same state.
            ring_next = T4;
            hlt_t4    = 1'b1;
          end
          default:                con = CON_IDLE;
        endcase
      end
      T5: begin
        ring_next = T6;
        case (bus.OPCODE)
          OP_LDA:         con = CON_CE_LA;
          OP_ADD, OP_SUB: con = CON_CE_LB;
          default:        con = CON_IDLE;
        endcase
      end
      T6: begin
        ring_next = T1;
        case (bus.OPCODE)
          OP_ADD:  con = CON_ADD_LA;
          OP_SUB:  con = CON_SUB_LA;
          default: con = CON_IDLE;
        endcase
      end
      // Any non-one-hot value recovers to T1 on the next edge.
      default: begin ring_next = T1; con = CON_IDLE; end
    endcase

    // Once halted the ring freezes and the datapath sees no activity,
    // whatever OPCODE does in the meantime.
    if (halt_q) begin
      ring_next = state_q;
      con       = CON_IDLE;
    end

    halt_out = halt_q | hlt_t4;

    if (advance) begin
      state_d = ring_next;
      halt_d  = halt_q | hlt_t4;
    end

    // CLR masks the outputs combinationally; the flops clear on the edge.
    if (CLR) begin
      state_d  = T1;
      halt_d   = 1'b0;
      con      = CON_IDLE;
      halt_out = 1'b0;
    end
  end

  assign bus.T    = state_q;
  assign bus.CON  = con;
  assign bus.HALT = halt_out;

endmodule

// File: tb/tb_sap1_controller.sv
// ----------------------------------------------------------------------------
// tb_sap1_controller
//   Directed bench for sap1_controller. Expected T/CON/HALT triples are
//   pushed to a scoreboard queue as each step is driven and popped when the
//   outputs are sampled, 1 time unit after the falling edge or after an
//   input change. Honors CTRL_SINGLE_STEP_EN for the single-step section.
// ----------------------------------------------------------------------------
module tb_sap1_controller;

  // clock / reset
  logic clk_n = 1'b1;
  logic clr;
  always #5 clk_n = ~clk_n;

  sap1_controller_if bus_if ();

  sap1_controller dut (
    .CLK_N (clk_n),
    .CLR   (clr),
    .bus   (bus_if)
  );

  // scoreboard: {T[5:0], CON[11:0], HALT}
  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  localparam logic [5:0] T1H = 6'b000001;
  localparam logic [5:0] T2H = 6'b000010;
  localparam logic [5:0] T3H = 6'b000100;
  localparam logic [5:0] T4H = 6'b001000;
  localparam logic [5:0] T5H = 6'b010000;

  task automatic push_exp(input string tag, input logic [5:0] t,
                          input logic [11:0] con, input logic halt);
    exp_q.push_back({t, con, halt});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [18:0] e;
    string       tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    n_assert++;
    assert (bus_if.T === e[18:13]) else begin
      n_fail++;
      $error("FAIL %s.T observed=%b expected=%b", tag, bus_if.T, e[18:13]);
    end
    n_assert++;
    assert (bus_if.CON === e[12:1]) else begin
      n_fail++;
      $error("FAIL %s.CON observed=%h expected=%h", tag, bus_if.CON, e[12:1]);
    end
    n_assert++;
    assert (bus_if.HALT === e[0]) else begin
      n_fail++;
      $error("FAIL %s.HALT observed=%b expected=%b", tag, bus_if.HALT, e[0]);
    end
  endtask

  task automatic expect_now(input string tag, input logic [5:0] t,
                            input logic [11:0] con, input logic halt);
    push_exp(tag, t, con, halt);
    check_out();
  endtask

  task automatic tick();
    @(negedge clk_n);
    #1;
  endtask

  // One full instruction starting from T1; OPCODE is scrambled during fetch
  // to show that fetch words do not depend on it. Ends back at T1.
  task automatic run_instr(input string name, input logic [3:0] op,
                           input logic [11:0] c4, input logic [11:0] c5,
                           input logic [11:0] c6);
    logic [11:0] words[6];
    words = '{12'h5E3, 12'hBE3, 12'h263, c4, c5, c6};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) bus_if.OPCODE = 4'($urandom_range(0, 15));
      else       bus_if.OPCODE = op;
      #1;
      expect_now($sformatf("%s_T%0d", name, i + 1), 6'(1 << i), words[i], 1'b0);
      tick();
    end
    expect_now($sformatf("%s_wrap", name), T1H, 12'h5E3, 1'b0);
  endtask

  initial begin
    // reset
    clr           = 1'b1;
    bus_if.OPCODE = 4'h0;
`ifdef CTRL_SINGLE_STEP_EN
    bus_if.STEP   = 1'b1;
`endif
    tick();
    tick();
    expect_now("reset_hold", T1H, 12'h3E3, 1'b0);
    clr = 1'b0;
    #1;
    expect_now("reset_release", T1H, 12'h5E3, 1'b0);

    // instructions
    run_instr("lda", 4'b0000, 12'h1A3, 12'h2C3, 12'h3E3);
    run_instr("add", 4'b0001, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr("sub", 4'b0010, 12'h1A3, 12'h2E1, 12'h3CF);
    run_instr("out", 4'b1110, 12'h3F2, 12'h3E3, 12'h3E3);
    run_instr("nop", 4'b0101, 12'h3E3, 12'h3E3, 12'h3E3);

    // HLT
    for (int i = 0; i < 3; i++) tick();
    bus_if.OPCODE = 4'b1111;
    #1;
    expect_now("hlt_t4", T4H, 12'h3E3, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      bus_if.OPCODE = 4'($urandom_range(0, 15));
      #1;
      expect_now($sformatf("hlt_hold%0d", i), T4H, 12'h3E3, 1'b1);
      tick();
    end
    clr = 1'b1;
    #1;
    expect_now("hlt_clr_comb", T4H, 12'h3E3, 1'b0);
    tick();
    expect_now("hlt_clr_edge", T1H, 12'h3E3, 1'b0);
    clr = 1'b0;
    #1;
    expect_now("hlt_clr_release", T1H, 12'h5E3, 1'b0);

    // CLR in the middle of an instruction
    bus_if.OPCODE = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    expect_now("mid_t5", T5H, 12'h2E1, 1'b0);
    clr = 1'b1;
    tick();
    expect_now("mid_clr", T1H, 12'h3E3, 1'b0);
    clr = 1'b0;
    #1;

`ifdef CTRL_SINGLE_STEP_EN
    // single step: hold while STEP=0, one state per edge with STEP=1
    bus_if.STEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_now($sformatf("step_hold%0d", i), T1H, 12'h5E3, 1'b0);
    end
    bus_if.STEP = 1'b1;
    tick();
    expect_now("step_t2", T2H, 12'hBE3, 1'b0);
    tick();
    expect_now("step_t3", T3H, 12'h263, 1'b0);
    bus_if.OPCODE = 4'b1111;
    tick();
    bus_if.STEP = 1'b0;
    #1;
    expect_now("step_hlt_t4", T4H, 12'h3E3, 1'b1);
    tick();
    expect_now("step_hlt_nostep", T4H, 12'h3E3, 1'b1);
    // The flag must not have set while STEP was low.
    bus_if.OPCODE = 4'b0000;
    #1;
    expect_now("step_hlt_noflag", T4H, 12'h1A3, 1'b0);
    bus_if.STEP = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
